// File: rtl/qe_input_filter_pkg.sv
// qe_input_filter_pkg
//   Shared defaults, register map constants and offsets for the QE input
//   glitch filter.
//   Ports: none (package).
package qe_input_filter_pkg;

   // Default widths for the filter instance parameters
   localparam int unsigned QE_DIV_WIDTH   = 16;
   localparam int unsigned QE_DEPTH_WIDTH = 4;
   localparam int unsigned QE_ERR_WIDTH   = 16;

   // Bit positions inside the QE config register
   localparam int unsigned QE_FILTER_ENABLE = 0;
   localparam int unsigned QE_FILTER_DEPTH  = 4;   // LSB of the depth field
   localparam int unsigned QE_CLEAR_ERRORS  = 8;

   // Register bank offsets served by the filter
   typedef enum logic [7:0] {
      QE_FILTER_DIV  = 8'h10,
      QE_ERROR_COUNT = 8'h14
   } qe_reg_offset_e;

endpackage

// File: rtl/qe_filter_bit.sv
// qe_filter_bit
//   One channel of the QE glitch filter: a stable counter qualifying level
//   changes over filter_depth consecutive sample ticks, plus the output
//   register.
//   Ports:
//     clk, reset (async, active-low)
//     sample_tick  - one-clk sample strobe from the prescaler
//     enable       - run enable; when low the counter clears, filt holds
//     filter_depth - consecutive differing samples required, 0 = bypass
//     raw          - synchronized input level
//     filt         - filtered output level
module qe_filter_bit
   import qe_input_filter_pkg::*;
#(
   parameter int unsigned DEPTH_WIDTH = QE_DEPTH_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sample_tick,
   input  logic                   enable,
   input  logic [DEPTH_WIDTH-1:0] filter_depth,
   input  logic                   raw,
   output logic                   filt
);

   logic [DEPTH_WIDTH-1:0] count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
         filt  <= 1'b0;
      end else if (!enable) begin
         count <= '0;
      end else if (filter_depth == '0) begin
         filt  <= raw;
         count <= '0;
      end else if (sample_tick) begin
         if (raw == filt) begin
            count <= '0;
         // >= rather than == so that lowering the depth mid-qualification
         // commits on the next differing tick instead of wrapping the count
         end else if (count >= filter_depth - DEPTH_WIDTH'(1)) begin
            filt  <= raw;
            count <= '0;
         end else begin
            count <= count + DEPTH_WIDTH'(1);
         end
      end
   end

endmodule

// File: rtl/qe_input_filter.sv
// qe_input_filter
//   Glitch filter and quadrature integrity checker between the QE input
//   synchronizers and the decoder (one instance per encoder channel).
//   Optional build macro: QE_FILTER_INDEX_GATE_EN - when defined, filt_I is
//   gated to the A=B=1 quadrant through one extra register stage.
//   Ports:
//     clk, reset (async, active-low)
//     enable        - filter run enable
//     sample_div    - sample tick period minus 1
//     filter_depth  - consecutive samples required, 0 = bypass
//     clear_errors  - single-cycle clear of error_count / error_sticky
//     raw_A/B/I     - synchronized encoder inputs
//     filt_A/B/I    - filtered outputs to the decoder
//     qe_error      - one-cycle pulse on an illegal A/B transition
//     error_count   - saturating illegal-transition count
//     error_sticky  - set on any illegal transition until cleared
module qe_input_filter
   import qe_input_filter_pkg::*;
#(
   parameter int unsigned DIV_WIDTH   = QE_DIV_WIDTH,
   parameter int unsigned DEPTH_WIDTH = QE_DEPTH_WIDTH,
   parameter int unsigned ERR_WIDTH   = QE_ERR_WIDTH
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   enable,
   input  logic [DIV_WIDTH-1:0]   sample_div,
   input  logic [DEPTH_WIDTH-1:0] filter_depth,
   input  logic                   clear_errors,
   input  logic                   raw_A,
   input  logic                   raw_B,
   input  logic                   raw_I,
   output logic                   filt_A,
   output logic                   filt_B,
   output logic                   filt_I,
   output logic                   qe_error,
   output logic [ERR_WIDTH-1:0]   error_count,
   output logic                   error_sticky
);

   logic [DIV_WIDTH-1:0] presc;
   logic                 sample_tick;
   logic                 idx_filt;
   logic                 prev_a;
   logic                 prev_b;
   logic                 err_now;

   // Prescaler: tick while at zero, then reload; sample_div is only
   // sampled at reload so a new period starts cleanly
   assign sample_tick = enable && (presc == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         presc <= '0;
      end else if (!enable || presc == '0) begin
         presc <= sample_div;
      end else begin
         presc <= presc - DIV_WIDTH'(1);
      end
   end

   qe_filter_bit #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_filt_a (
      .clk          (clk),
      .reset        (reset),
      .sample_tick  (sample_tick),
      .enable       (enable),
      .filter_depth (filter_depth),
      .raw          (raw_A),
      .filt         (filt_A)
   );

   qe_filter_bit #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_filt_b (
      .clk          (clk),
      .reset        (reset),
      .sample_tick  (sample_tick),
      .enable       (enable),
      .filter_depth (filter_depth),
      .raw          (raw_B),
      .filt         (filt_B)
   );

   qe_filter_bit #(.DEPTH_WIDTH(DEPTH_WIDTH)) u_filt_i (
      .clk          (clk),
      .reset        (reset),
      .sample_tick  (sample_tick),
      .enable       (enable),
      .filter_depth (filter_depth),
      .raw          (raw_I),
      .filt         (idx_filt)
   );

`ifdef QE_FILTER_INDEX_GATE_EN
   logic idx_gated;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         idx_gated <= 1'b0;
      end else begin
         idx_gated <= idx_filt & filt_A & filt_B;
      end
   end

   assign filt_I = idx_gated;
`else
   assign filt_I = idx_filt;
`endif

   // Both filtered phases moving in the same clk is an illegal step
   assign err_now = enable && (prev_a != filt_A) && (prev_b != filt_B);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         prev_a <= 1'b0;
         prev_b <= 1'b0;
      end else begin
         prev_a <= filt_A;
         prev_b <= filt_B;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         qe_error     <= 1'b0;
         error_count  <= '0;
         error_sticky <= 1'b0;
      end else begin
         qe_error <= err_now;
         // clear wins over a coincident error; the pulse is still reported
         if (clear_errors) begin
            error_count  <= '0;
            error_sticky <= 1'b0;
         end else if (err_now) begin
            error_sticky <= 1'b1;
            if (error_count != '1) begin
               error_count <= error_count + ERR_WIDTH'(1);
            end
         end
      end
   end

endmodule
